// File: rtl/cic_capture_buf.sv
// Captures DEPTH decimated CIC words after a trigger and streams them out serially.
// Latency: SDO_VLD rises one edge after RD_REQ is sampled in READY; then DEPTH*(BW+4) bits.
// Backpressure: none; IN_VLD strobes are dropped outside CAPTURE or while ENABLE is low.
//
// Ports:
//   CLK, RES         clock, synchronous active-high reset
//   ENABLE           capture enable (qualifies TRIG in IDLE and IN_VLD in CAPTURE)
//   IN, IN_VLD       signed BW+4-bit CIC word and its one-cycle strobe
//   TRIG, RD_REQ     start-capture and start-readout pulses
//   SDO, SDO_VLD     serial data (MSB first) and its valid flag
//   FRAME            marks the MSB bit of each word
//   BUSY, READY      status: capturing/reading out, buffer full
//   CNT              words captured in the current capture (0..DEPTH)
module cic_capture_buf #(
  parameter int BW    = 6,
  parameter int DEPTH = 16
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          ENABLE,
  input  logic [BW+3:0] IN,
  input  logic          IN_VLD,
  input  logic          TRIG,
  input  logic          RD_REQ,
  output logic          SDO,
  output logic          SDO_VLD,
  output logic          FRAME,
  output logic          BUSY,
  output logic          READY,
  output logic [6:0]    CNT
);

  localparam int W    = BW + 4;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BITW = (W > 1) ? $clog2(W) : 1;

  localparam logic [BITW-1:0] BIT_MSB   = BITW'(W - 1);
  localparam logic [AW-1:0]   WORD_LAST = AW'(DEPTH - 1);
  localparam logic [6:0]      CNT_LAST  = 7'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  // Capture buffer; never reset because it is only readable after a full capture.
  logic [W-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [AW-1:0]   word_q, word_d;   // word currently on SDO
  logic [BITW-1:0] bit_q, bit_d;     // bit currently on SDO
  logic            sdo_q, sdo_d;
  logic            vld_q, vld_d;
  logic            frame_q, frame_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    bit_d   = bit_q;
    sdo_d   = 1'b0;
    vld_d   = 1'b0;
    frame_d = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (TRIG && ENABLE) begin
          state_d = ST_CAPTURE;
          cnt_d   = 7'd0;
        end
      end

      ST_CAPTURE: begin
        if (IN_VLD && ENABLE) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
          end
        end
      end

      ST_READY: begin
        // RD_REQ beats a coincident TRIG.
        if (RD_REQ) begin
          state_d = ST_READOUT;
          word_d  = '0;
          bit_d   = BIT_MSB;
          sdo_d   = mem[0][W-1];
          vld_d   = 1'b1;
          frame_d = 1'b1;
        end else if (TRIG) begin
          state_d = ST_CAPTURE;
          cnt_d   = 7'd0;
        end
      end

      ST_READOUT: begin
        if (word_q == WORD_LAST && bit_q == '0) begin
          state_d = ST_IDLE;
          word_d  = '0;
          bit_d   = '0;
        end else begin
          if (bit_q == '0) begin
            bit_d  = BIT_MSB;
            word_d = word_q + AW'(1);
          end else begin
            bit_d  = bit_q - BITW'(1);
          end
          sdo_d   = mem[word_d][bit_d];
          vld_d   = 1'b1;
          frame_d = (bit_d == BIT_MSB);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status flags follow the next state so they change on the same edge as the FSM.
    busy_d  = (state_d == ST_CAPTURE) || (state_d == ST_READOUT);
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_IDLE;
      cnt_q   <= 7'd0;
      word_q  <= '0;
      bit_q   <= '0;
      sdo_q   <= 1'b0;
      vld_q   <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      sdo_q   <= sdo_d;
      vld_q   <= vld_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RES) begin
      mem[cnt_q[AW-1:0]] <= IN;
    end
  end

  assign SDO     = sdo_q;
  assign SDO_VLD = vld_q;
  assign FRAME   = frame_q;
  assign BUSY    = busy_q;
  assign READY   = ready_q;
  assign CNT     = cnt_q;

endmodule

// File: doc/cic_capture_buf.md
CIC_CAPTURE_BUF -- requirements
Module: cic_capture_buf

Interface
REQ-001 Parameter BW, default 6, ADC/CIC input width; captured word width is BW+4 (10 bits at default).
REQ-002 Parameter DEPTH, default 16, number of words per capture; power of two, 2..64.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RES  input  1  reset: one clock; reset is synchronous and active-high.
REQ-005 ENABLE  input  1  capture enable; while low, IN_VLD is ignored.
REQ-006 IN  input  BW+4  signed decimated CIC output word.
REQ-007 IN_VLD  input  1  one-cycle strobe marking a valid IN word.
REQ-008 TRIG  input  1  one-cycle pulse that starts a capture.
REQ-009 RD_REQ  input  1  one-cycle pulse that starts serial readout.
REQ-010 SDO  output  1  serial data, MSB first.
REQ-011 SDO_VLD  output  1  high while SDO carries a valid bit.
REQ-012 FRAME  output  1  high on the MSB bit of each word.
REQ-013 BUSY  output  1  high in CAPTURE or READOUT.
REQ-014 READY  output  1  high in READY (buffer full, not yet read).
REQ-015 CNT  output  7  number of words captured in the current capture, 0..DEPTH.

Function
REQ-016 The block SHALL implement a four-state FSM with states IDLE, CAPTURE, READY and READOUT; all outputs SHALL be registered.
REQ-017 IDLE: if TRIG=1 and ENABLE=1 -> CAPTURE, CNT cleared to 0; otherwise stay.
REQ-018 An IN_VLD in the same cycle as the accepted TRIG SHALL NOT be stored; the first stored word is the next qualifying IN_VLD.
REQ-019 CAPTURE: each cycle with IN_VLD=1 and ENABLE=1 SHALL write IN to mem[CNT] and increment CNT.
REQ-020 CAPTURE: the write that brings CNT to DEPTH SHALL move the FSM to READY on the same edge.
REQ-021 CAPTURE with ENABLE=0 SHALL pause: nothing is written and the state is held.
REQ-022 TRIG in CAPTURE or READOUT SHALL be ignored.
REQ-023 READY: RD_REQ=1 -> READOUT. TRIG=1 with RD_REQ=0 -> CAPTURE with CNT cleared (restart; old data discarded).
REQ-024 READY: if RD_REQ and TRIG are high in the same cycle, RD_REQ SHALL win.
REQ-025 Readout latency: SDO_VLD SHALL rise on the edge after RD_REQ is sampled.
REQ-026 Readout SHALL then stay high for exactly DEPTH*(BW+4) consecutive cycles (160 at defaults).
REQ-027 Readout order: words mem[0]..mem[DEPTH-1]; within each word, bit BW+3 first down to bit 0.
REQ-028 FRAME SHALL be high exactly on each bit BW+3 cycle.
REQ-029 After the last bit (word DEPTH-1, bit 0): the following edge SHALL clear SDO_VLD, FRAME and SDO and set the state to IDLE; CNT holds DEPTH until the next TRIG.
REQ-030 READOUT SHALL be unaffected by ENABLE, IN_VLD, TRIG and RD_REQ.
REQ-031 RD_REQ outside READY SHALL be ignored.
REQ-032 IN_VLD outside CAPTURE SHALL be ignored.
REQ-033 Output flags: BUSY=1 in CAPTURE and READOUT; READY=1 only in READY; SDO=0 whenever SDO_VLD=0.
REQ-034 Data SHALL be stored and shifted bit-exact (two's complement, no rounding or saturation).

Reset
REQ-035 RES=1 at an edge SHALL force IDLE with SDO=0, SDO_VLD=0, FRAME=0, BUSY=0, READY=0, CNT=0 and internal bit/word counters at 0, in any state including mid-capture and mid-readout.
REQ-036 Buffer memory SHALL NOT be reset; it is never observable before a full capture.
REQ-037 RES SHALL take priority over all other inputs in the same cycle.

Verification
REQ-038 Basic path: TRIG, then 16 IN_VLD strobes with IN = -8..7, then RD_REQ -> READY rises on the edge of the 16th write; SDO_VLD rises 1 cycle after RD_REQ and lasts 160 cycles; the first word shifted is 10'b1111111000; FRAME is high 16 times; the FSM returns to IDLE.
REQ-039 Pause/ignore: ENABLE=0 for 5 IN_VLD strobes mid-capture, plus an IN_VLD coincident with TRIG -> none of these stored; CNT increments only on qualifying strobes.
REQ-040 Priority: in READY, assert TRIG and RD_REQ together -> readout starts and the data is unchanged; then in READY, TRIG alone -> CAPTURE with CNT=0 and READY=0.
REQ-041 Reset mid-operation: RES at capture word 7, and again at readout bit 50 -> all outputs 0 on the next edge; a fresh TRIG capture afterwards reads out correctly.
REQ-042 Ignored inputs: RD_REQ in IDLE/CAPTURE, and TRIG/IN_VLD during READOUT -> no state change, serial stream bit-identical to the reference model.
